// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the ID/EX pipeline datapath and the hazard controller.
// With HAZARD_STATS_EN defined the bundle also carries the stall counter.
interface pipeline_hazard_ctrl_if;
  localparam int unsigned REG_IDX_W = 4;
  localparam int unsigned SRC_N     = 3;
  localparam int unsigned STATE_W   = 2;

  // ID stage source operands
  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic [REG_IDX_W-1:0] id_rs3;
  logic [SRC_N-1:0]     id_src_valid;
  logic                 id_vector;

  // ID/EX control fields
  logic [REG_IDX_W-1:0] ex_rr;
  logic                 ex_memread;
  logic                 ex_regswrite;
  logic                 ex_regvwrite;
  logic                 ex_vectorop;
  logic                 ex_branch_taken;

  // pipeline controls
  logic                 pc_write;
  logic                 ifid_write;
  logic                 ifid_flush;
  logic                 idex_bubble;
  logic                 idex_hold;
  logic [STATE_W-1:0]   state;

`ifdef HAZARD_STATS_EN
  logic [15:0]          stall_count;

  modport master (
    output id_rs1, id_rs2, id_rs3, id_src_valid, id_vector,
    output ex_rr, ex_memread, ex_regswrite, ex_regvwrite, ex_vectorop, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, state, stall_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs3, id_src_valid, id_vector,
    input  ex_rr, ex_memread, ex_regswrite, ex_regvwrite, ex_vectorop, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, state, stall_count
  );
`else
  modport master (
    output id_rs1, id_rs2, id_rs3, id_src_valid, id_vector,
    output ex_rr, ex_memread, ex_regswrite, ex_regvwrite, ex_vectorop, ex_branch_taken,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, state
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs3, id_src_valid, id_vector,
    input  ex_rr, ex_memread, ex_regswrite, ex_regvwrite, ex_vectorop, ex_branch_taken,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, state
  );
`endif
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle vector EX stalls
// and taken-branch flushes, priority branch > vector > load-use.
// Pipeline controls are combinational so they settle within the high phase,
// ahead of the negedge where the pipeline registers sample them.
// Optional feature macro: HAZARD_STATS_EN adds a saturating 16-bit stall_count.
module pipeline_hazard_ctrl #(
  parameter int unsigned VEC_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  pipeline_hazard_ctrl_if.slave  bus
);
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] VEC_LOAD = CNT_W'(VEC_CYCLES - 1);
  // a single-cycle vector op completes in EX like any scalar op
  localparam bit VEC_STALL_EN = (VEC_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_VEC_BUSY = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       src_hit_c;
  logic             load_use_c;
  logic             vec_start_c;
  logic             pc_write_c;
  logic             ifid_write_c;
  logic             ifid_flush_c;
  logic             idex_bubble_c;
  logic             idex_hold_c;

  // Load-use detection; scalar R0 is hardwired and never a real dependency
  always_comb begin
    src_hit_c[0] = bus.id_src_valid[0] && (bus.id_rs1 == bus.ex_rr) &&
                   (bus.id_vector || (bus.id_rs1 != '0));
    src_hit_c[1] = bus.id_src_valid[1] && (bus.id_rs2 == bus.ex_rr) &&
                   (bus.id_vector || (bus.id_rs2 != '0));
    src_hit_c[2] = bus.id_src_valid[2] && (bus.id_rs3 == bus.ex_rr) &&
                   (bus.id_vector || (bus.id_rs3 != '0));
    load_use_c   = bus.ex_memread && (|src_hit_c) &&
                   ((!bus.id_vector && bus.ex_regswrite) ||
                    (bus.id_vector && bus.ex_regvwrite));
    vec_start_c  = VEC_STALL_EN && bus.ex_vectorop;
  end

  // Next state, stall counter and pipeline controls; reset forces RUN outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    idex_hold_c   = 1'b0;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (bus.ex_branch_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = ST_FLUSH;
          end else if (vec_start_c) begin
            state_d = ST_VEC_BUSY;
            cnt_d   = VEC_LOAD;
          end else if (load_use_c) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
          end
        end
        ST_VEC_BUSY: begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_hold_c  = 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_FLUSH: begin
          ifid_flush_c  = 1'b1;
          idex_bubble_c = 1'b1;
          state_d       = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and vector-occupancy counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ifid_write  = ifid_write_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.idex_hold   = idex_hold_c;
  assign bus.state       = state_q;

`ifdef HAZARD_STATS_EN
  localparam int unsigned STALL_W = 16;

  logic [STALL_W-1:0] stall_q, stall_d;

  // Count frozen-PC cycles, saturating at all ones
  always_comb begin
    stall_d = stall_q;
    if (!pc_write_c && (stall_q != '1)) begin
      stall_d = stall_q + STALL_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_count = stall_q;
`else
  // no statistics hardware in this build
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
  localparam int unsigned VEC_CYCLES = 4;
  localparam int unsigned RAND_CYCLES = 3000;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hif ();

  pipeline_hazard_ctrl #(.VEC_CYCLES(VEC_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: remaining busy cycles, pending flush, stall total
  int busy_left   = 0;
  bit flush_pend  = 1'b0;
  int stall_model = 0;

  // observation counters for directed scenarios
  int pc_low_cnt = 0;
  int hold_cnt   = 0;
  int flush_cnt  = 0;
  int busy_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit load_use_ref();
    logic [3:0] rs [3];
    rs[0] = hif.id_rs1;
    rs[1] = hif.id_rs2;
    rs[2] = hif.id_rs3;
    if (!hif.ex_memread) return 1'b0;
    if (hif.id_vector && !hif.ex_regvwrite) return 1'b0;
    if (!hif.id_vector && !hif.ex_regswrite) return 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (hif.id_src_valid[i] && rs[i] == hif.ex_rr && (hif.id_vector || rs[i] != 4'd0))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // One cycle: drive at negedge, check just after, then advance the model
  task automatic step(input bit r, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [3:0] s3, input logic [2:0] sv, input bit vec,
                      input logic [3:0] rr, input bit mr, input bit sw, input bit vw,
                      input bit vop, input bit br);
    bit e_pc, e_ifw, e_fl, e_bub, e_hold;
    int e_state;
    @(negedge clk);
    rst                 = r;
    hif.id_rs1          = s1;
    hif.id_rs2          = s2;
    hif.id_rs3          = s3;
    hif.id_src_valid    = sv;
    hif.id_vector       = vec;
    hif.ex_rr           = rr;
    hif.ex_memread      = mr;
    hif.ex_regswrite    = sw;
    hif.ex_regvwrite    = vw;
    hif.ex_vectorop     = vop;
    hif.ex_branch_taken = br;
    #1;
    if (!r) begin
      busy_left   = 0;
      flush_pend  = 1'b0;
      stall_model = 0;
    end
    e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_hold = 0; e_state = 0;
    if (r) begin
      if (busy_left > 0) begin
        e_pc = 0; e_ifw = 0; e_hold = 1; e_state = 1;
      end else if (flush_pend) begin
        e_fl = 1; e_bub = 1; e_state = 2;
      end else if (br) begin
        e_fl = 1; e_bub = 1;
      end else if (vop && VEC_CYCLES > 1) begin
        // vector op enters EX; stall starts next cycle
      end else if (load_use_ref()) begin
        e_pc = 0; e_ifw = 0; e_bub = 1;
      end
    end
    check_eq("pc_write",    32'(hif.pc_write),    32'(e_pc));
    check_eq("ifid_write",  32'(hif.ifid_write),  32'(e_ifw));
    check_eq("ifid_flush",  32'(hif.ifid_flush),  32'(e_fl));
    check_eq("idex_bubble", 32'(hif.idex_bubble), 32'(e_bub));
    check_eq("idex_hold",   32'(hif.idex_hold),   32'(e_hold));
    check_eq("state",       32'(hif.state),       32'(e_state));
    check_eq("hold_bubble_excl", 32'(hif.idex_hold & hif.idex_bubble), 32'd0);
`ifdef HAZARD_STATS_EN
    check_eq("stall_count", 32'(hif.stall_count), 32'(stall_model));
`endif
    if (hif.pc_write == 1'b0)   pc_low_cnt++;
    if (hif.idex_hold == 1'b1)  hold_cnt++;
    if (hif.ifid_flush == 1'b1) flush_cnt++;
    if (hif.state == 2'd1)      busy_cnt++;
    if (r) begin
      if (!e_pc && stall_model < 65535) stall_model++;
      if (busy_left > 0) begin
        busy_left--;
      end else if (flush_pend) begin
        flush_pend = 1'b0;
      end else if (br) begin
        flush_pend = 1'b1;
      end else if (vop && VEC_CYCLES > 1) begin
        busy_left = VEC_CYCLES - 1;
      end
    end
  endtask

  task automatic idle();
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    pc_low_cnt = 0; hold_cnt = 0; flush_cnt = 0; busy_cnt = 0;
  endtask

  initial begin
    rst = 1'b0;
    hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_rs3 = '0; hif.id_src_valid = '0;
    hif.id_vector = 1'b0; hif.ex_rr = '0; hif.ex_memread = 1'b0;
    hif.ex_regswrite = 1'b0; hif.ex_regvwrite = 1'b0; hif.ex_vectorop = 1'b0;
    hif.ex_branch_taken = 1'b0;

    // reset holds RUN outputs even with hazard/branch inputs present
    step(1'b0, 4'd0, 4'd5, 4'd0, 3'b010, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle();

    // scalar load R5, ID reads rs2=R5: one stall cycle
    clear_obs();
    step(1'b1, 4'd0, 4'd5, 4'd0, 3'b010, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    check_eq("lu_r5_stall_cycles", 32'(pc_low_cnt), 32'd1);

    // R0 never hazards; vector load vs scalar read of R3 does not hazard
    clear_obs();
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b001, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 4'd3, 4'd0, 4'd0, 3'b001, 1'b0, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("no_hazard_stalls", 32'(pc_low_cnt), 32'd0);

    // vector op pulse: VEC_CYCLES-1 hold cycles
    clear_obs();
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) idle();
    check_eq("vec_hold_cycles", 32'(hold_cnt), 32'(VEC_CYCLES - 1));
    check_eq("vec_busy_cycles", 32'(busy_cnt), 32'(VEC_CYCLES - 1));

    // branch with vector op: branch wins, two flush cycles, no VEC_BUSY
    clear_obs();
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) idle();
    check_eq("br_vec_flush_cycles", 32'(flush_cnt), 32'd2);
    check_eq("br_vec_busy_cycles",  32'(busy_cnt),  32'd0);

    // reset on the second VEC_BUSY cycle aborts the stall
    step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    step(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_obs();
    for (int i = 0; i < 4; i++) idle();
    check_eq("rst_abort_stalls", 32'(pc_low_cnt), 32'd0);

`ifdef HAZARD_STATS_EN
    // two vector ops accumulate 2*(VEC_CYCLES-1) stalls from reset
    step(1'b0, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'd0, 4'd0, 4'd0, 3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) idle();
    end
    check_eq("stats_two_vec", 32'(hif.stall_count), 32'(2 * (VEC_CYCLES - 1)));
`endif

    // randomized traffic, small register range to make hazards frequent
    for (int n = 0; n < RAND_CYCLES; n++) begin
      step($urandom_range(0, 49) != 0,
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
